// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the IF/ID, ID/EX, EX/MEM, MEM/WB latches of the 5-stage core
// Ports: CLK, RST (sync, active-high); ihit/dhit fetch and data-access completion; mem_ren/mem_wen MEM access;
//   ex_memread/ex_rt/id_rs/id_rt load-use compare; jump_id/branch_ex redirects; halt_mem halt in MEM;
//   pc_en and per-latch *_en/*_flush controls; halt_out sticky halted flag.
// PIPE_PERF_EN adds CNT_W-wide stall_cycles and flush_events counters.
module pipeline_ctrl #(
  parameter int REG_W = 5
`ifdef PIPE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_ren,
  input  logic             mem_wen,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             jump_id,
  input  logic             branch_ex,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt_out
`ifdef PIPE_PERF_EN
  , output logic [CNT_W-1:0] stall_cycles
  , output logic [CNT_W-1:0] flush_events
`endif
);
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;
  state_t state_q, state_d;
  logic load_use, mem_stall, redirect;
  assign load_use = ex_memread && ex_rt != '0 && (ex_rt == id_rs || ex_rt == id_rt);
  // DWAIT keeps stalling on !dhit even if the request lines drop
  assign mem_stall = (state_q == DWAIT || mem_ren || mem_wen) && !dhit;
  always_ff @(posedge CLK) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    halt_out    = 1'b0;
    redirect    = 1'b0;
    state_d     = state_q;
    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_d     = RUN;
    end else if (state_q == HALTED) begin
      halt_out = 1'b1;
    end else if (mem_stall) begin
      memwb_flush = 1'b1;
      state_d     = DWAIT;
    end else if (halt_mem) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_en    = 1'b1;
      state_d     = HALTED;
    end else if (branch_ex) begin
      pc_en      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      redirect   = 1'b1;
      state_d    = RUN;
    end else if (load_use) begin
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      state_d    = RUN;
    end else begin
      // jump redirects the PC and squashes IF/ID; a fetch miss bubbles IF/ID and holds the PC
      pc_en      = jump_id || ihit;
      ifid_flush = jump_id || !ihit;
      ifid_en    = !jump_id && ihit;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      redirect   = jump_id;
      state_d    = RUN;
    end
  end
`ifdef PIPE_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (state_q != HALTED) begin
      if (!pc_en) stall_cycles <= stall_cycles + 1'b1;
      if (redirect) flush_events <= flush_events + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a case-table reference model
module tb_pipeline_ctrl;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST, ihit, dhit, mem_ren, mem_wen, ex_memread, jump_id, branch_ex, halt_mem;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush, halt_out;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif
  pipeline_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .jump_id(jump_id), .branch_ex(branch_ex), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halt_out(halt_out)
`ifdef PIPE_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );
  logic [9:0] outv;
  assign outv = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush, halt_out};
  int n_run = 0;
  int n_fail = 0;
  bit m_wait, m_halt;
  int unsigned m_stall, m_flush;
  function automatic int mcase();
    if (RST) return 0;
    if (m_halt) return 1;
    if ((m_wait || mem_ren || mem_wen) && !dhit) return 2;
    if (halt_mem) return 3;
    if (branch_ex) return 4;
    if (ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt)) return 5;
    if (jump_id) return 6;
    if (!ihit) return 7;
    return 8;
  endfunction
  // {pc, ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl, halt}
  function automatic logic [9:0] vec(input int c);
    case (c)
      0: return 10'b0_01_01_01_01_0;
      1: return 10'b0_00_00_00_00_1;
      2: return 10'b0_00_00_00_01_0;
      3: return 10'b0_01_01_01_10_0;
      4: return 10'b1_01_01_10_10_0;
      5: return 10'b0_00_01_10_10_0;
      6: return 10'b1_01_10_10_10_0;
      7: return 10'b0_01_10_10_10_0;
      default: return 10'b1_10_10_10_10_0;
    endcase
  endfunction
  function automatic logic [9:0] expv();
    return vec(mcase());
  endfunction
  task automatic adv();
    int c;
    logic [9:0] v;
    c = mcase();
    v = vec(c);
    if (c == 0) begin
      m_wait = 0; m_halt = 0; m_stall = 0; m_flush = 0;
    end else if (c != 1) begin
      if (!v[9]) m_stall++;
      if (c == 4 || c == 6) m_flush++;
      m_wait = (c == 2);
      if (c == 3) m_halt = 1;
    end
    @(negedge CLK);
    #1;
  endtask
  task automatic idle();
    RST = 0; ihit = 1; dhit = 1; mem_ren = 0; mem_wen = 0; ex_memread = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0; jump_id = 0; branch_ex = 0; halt_mem = 0;
  endtask
  task automatic test_reset();
    idle();
    RST = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_run++;
      if (outv !== 10'b0_01_01_01_01_0 || outv !== expv()) begin
        n_fail++; $display("FAIL reset[%0d]: got %b want %b", i, outv, expv());
      end
      adv();
    end
    RST = 0;
    #1;
    n_run++;
    if (outv !== 10'b1_10_10_10_10_0 || outv !== expv()) begin
      n_fail++; $display("FAIL reset_release: got %b want %b", outv, expv());
    end
    adv();
  endtask
  task automatic test_load_use();
    idle();
    ex_memread = 1; ex_rt = 5; id_rs = 5;
    #1;
    n_run++;
    if (pc_en !== 0 || ifid_en !== 0 || idex_flush !== 1 || outv !== expv()) begin
      n_fail++; $display("FAIL load_use: got %b want %b", outv, expv());
    end
    adv();
    ex_rt = 7; id_rs = 2; id_rt = 7;
    #1;
    n_run++;
    if (pc_en !== 0 || outv !== expv()) begin
      n_fail++; $display("FAIL load_use_rt: got %b want %b", outv, expv());
    end
    adv();
    ex_rt = 0; id_rs = 0; id_rt = 0;
    #1;
    n_run++;
    if (pc_en !== 1 || ifid_en !== 1 || outv !== expv()) begin
      n_fail++; $display("FAIL load_use_r0: got %b want %b", outv, expv());
    end
    adv();
  endtask
  task automatic test_mem_stall();
    idle();
    mem_ren = 1; dhit = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if (memwb_flush !== 1 || pc_en !== 0 || outv !== 10'b0_00_00_00_01_0 || outv !== expv()) begin
        n_fail++; $display("FAIL mem_stall[%0d]: got %b want %b", i, outv, expv());
      end
      adv();
    end
    dhit = 1;
    #1;
    n_run++;
    if (outv !== 10'b1_10_10_10_10_0 || outv !== expv()) begin
      n_fail++; $display("FAIL mem_stall_done: got %b want %b", outv, expv());
    end
    adv();
    mem_ren = 0; dhit = 0;
    #1;
    n_run++;
    if (pc_en !== 1 || outv !== expv()) begin
      n_fail++; $display("FAIL mem_stall_back_to_run: got %b want %b", outv, expv());
    end
    adv();
    mem_wen = 1; dhit = 0;
    #1;
    adv();
    dhit = 1; ihit = 0;
    #1;
    n_run++;
    if (outv !== 10'b0_01_10_10_10_0 || outv !== expv()) begin
      n_fail++; $display("FAIL mem_stall_ihit_miss: got %b want %b", outv, expv());
    end
    adv();
  endtask
  task automatic test_branch_vs_load_use();
    idle();
    branch_ex = 1; jump_id = 1; ex_memread = 1; ex_rt = 9; id_rt = 9;
    #1;
    n_run++;
    if (ifid_flush !== 1 || idex_flush !== 1 || pc_en !== 1 || outv !== expv()) begin
      n_fail++; $display("FAIL branch_vs_load_use: got %b want %b", outv, expv());
    end
    adv();
    branch_ex = 0;
    #1;
    n_run++;
    if (pc_en !== 0 || ifid_flush !== 0 || outv !== expv()) begin
      n_fail++; $display("FAIL load_use_vs_jump: got %b want %b", outv, expv());
    end
    adv();
  endtask
  task automatic test_halt();
    idle();
    halt_mem = 1; mem_ren = 1; dhit = 0;
    #1;
    n_run++;
    if (outv !== 10'b0_00_00_00_01_0 || outv !== expv()) begin
      n_fail++; $display("FAIL halt_vs_stall: got %b want %b", outv, expv());
    end
    adv();
    dhit = 1;
    #1;
    n_run++;
    if (outv !== 10'b0_01_01_01_10_0 || outv !== expv()) begin
      n_fail++; $display("FAIL halt_drain: got %b want %b", outv, expv());
    end
    adv();
    idle();
    for (int i = 0; i < 10; i++) begin
      jump_id = (i == 4);
      branch_ex = (i == 6);
      #1;
      n_run++;
      if (halt_out !== 1 || outv !== 10'b0_00_00_00_00_1 || outv !== expv()) begin
        n_fail++; $display("FAIL halted[%0d]: got %b want %b", i, outv, expv());
      end
      adv();
    end
    RST = 1;
    #1;
    n_run++;
    if (outv !== 10'b0_01_01_01_01_0 || outv !== expv()) begin
      n_fail++; $display("FAIL halt_reset: got %b want %b", outv, expv());
    end
    adv();
    idle();
    #1;
    n_run++;
    if (halt_out !== 0 || outv !== expv()) begin
      n_fail++; $display("FAIL halt_exit: got %b want %b", outv, expv());
    end
    adv();
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      RST = ($urandom_range(0, 99) < 3);
      ihit = ($urandom_range(0, 99) < 80);
      dhit = ($urandom_range(0, 99) < 60);
      mem_ren = ($urandom_range(0, 99) < 20);
      mem_wen = ($urandom_range(0, 99) < 10);
      ex_memread = ($urandom_range(0, 99) < 40);
      ex_rt = 5'($urandom_range(0, 3));
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      jump_id = ($urandom_range(0, 99) < 15);
      branch_ex = ($urandom_range(0, 99) < 15);
      halt_mem = ($urandom_range(0, 99) < 2);
      #1;
      n_run++;
      if (outv !== expv()) begin
        n_fail++; $display("FAIL random[%0d]: got %b want %b", i, outv, expv());
      end
`ifdef PIPE_PERF_EN
      n_run++;
      if (stall_cycles !== m_stall || flush_events !== m_flush) begin
        n_fail++; $display("FAIL random_perf[%0d]: got %0d/%0d want %0d/%0d", i, stall_cycles, flush_events, m_stall, m_flush);
      end
`endif
      adv();
    end
  endtask
`ifdef PIPE_PERF_EN
  task automatic test_perf();
    idle();
    RST = 1;
    #1;
    adv();
    idle();
    mem_ren = 1; dhit = 0;
    #1;
    for (int i = 0; i < 3; i++) adv();
    dhit = 1;
    #1;
    adv();
    idle();
    branch_ex = 1;
    #1;
    adv();
    branch_ex = 0;
    #1;
    adv();
    branch_ex = 1;
    #1;
    adv();
    idle();
    #1;
    n_run++;
    if (stall_cycles !== 3 || flush_events !== 2 || stall_cycles !== m_stall || flush_events !== m_flush) begin
      n_fail++; $display("FAIL perf_counts: got %0d/%0d want 3/2", stall_cycles, flush_events);
    end
    RST = 1;
    #1;
    adv();
    n_run++;
    if (stall_cycles !== 0 || flush_events !== 0) begin
      n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cycles, flush_events);
    end
    idle();
  endtask
`endif
  initial begin
    test_reset();
    test_load_use();
    test_mem_stall();
    test_branch_vs_load_use();
    test_halt();
    test_random();
`ifdef PIPE_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
